// File: rtl/gcm_auth_release_if.sv
// Handshake/bus bundle for gcm_auth_release: plaintext in, tags in, released plaintext and status out.
// Vectors use [0:127] numbering so that bit 0 is the MSB.
interface gcm_auth_release_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic           start;
  logic           pt_valid;
  logic [0:127]   pt_block;
  logic           pt_ready;
  logic           tag_ready;
  logic [0:127]   computed_tag;
  logic [0:127]   expected_tag;
  logic           out_valid;
  logic [0:127]   out_block;
  logic           out_ready;
  logic           auth_ok;
  logic           auth_fail;
  logic           overflow;
  logic           timeout;
  logic           busy;
  logic [CW-1:0]  block_count;

  modport slave (
    input  start, pt_valid, pt_block, tag_ready, computed_tag, expected_tag, out_ready,
    output pt_ready, out_valid, out_block, auth_ok, auth_fail, overflow, timeout, busy, block_count
  );

  modport master (
    output start, pt_valid, pt_block, tag_ready, computed_tag, expected_tag, out_ready,
    input  pt_ready, out_valid, out_block, auth_ok, auth_fail, overflow, timeout, busy, block_count
  );
endinterface

// File: rtl/gcm_auth_release.sv
// Receive-side AES-GCM gate: buffers decrypted blocks and releases them only after a tag match.
// Optional COLLECT idle timeout enabled by defining GCM_AUTH_TIMEOUT_EN.
module gcm_auth_release #(
  parameter int DEPTH          = 4,
  parameter int TAG_BITS       = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_out,
  input  logic                 i_reset,
  gcm_auth_release_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // Ones in bit positions 0..TAG_BITS-1 (the MSBs), which are the only ones compared.
  localparam logic [0:127] TAG_MASK = {128{1'b1}} << (128 - TAG_BITS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    COMPARE = 3'd2,
    RELEASE = 3'd3,
    FLUSH   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t         state_r, next_s;
  logic [0:127]   mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]  fill_r, count_r;
  logic [0:127]   comp_tag_r, exp_tag_r;
  logic           auth_ok_r, auth_fail_r, overflow_r;
  logic           full_s, empty_s, push_s, pop_s, out_valid_s, match_s, timeout_hit_s;

  assign full_s      = (fill_r == CW'(DEPTH));
  assign empty_s     = (fill_r == {CW{1'b0}});
  assign push_s      = (state_r == COLLECT) && bus.pt_valid && !full_s;
  assign out_valid_s = (state_r == RELEASE) && !empty_s;
  assign pop_s       = out_valid_s && bus.out_ready;
  // Constant-time compare: whole masked difference is reduced, overflow forces a mismatch.
  assign match_s     = !(|((comp_tag_r ^ exp_tag_r) & TAG_MASK)) && !overflow_r;

`ifdef GCM_AUTH_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] timer_r;
  logic          timeout_r;

  assign timeout_hit_s = (state_r == COLLECT) && !push_s && (timer_r == TW'(TIMEOUT_CYCLES - 1));

  // COLLECT idle timer, restarted on entry and on every accepted block
  always_ff @(posedge clk_out) begin
    if (i_reset || bus.start || (state_r != COLLECT) || push_s) begin
      timer_r <= {TW{1'b0}};
    end else if (timer_r != TW'(TIMEOUT_CYCLES - 1)) begin
      timer_r <= timer_r + TW'(1);
    end else begin
      timer_r <= timer_r;
    end
  end

  // Sticky timeout flag
  always_ff @(posedge clk_out) begin
    if (i_reset || bus.start) begin
      timeout_r <= 1'b0;
    end else if (timeout_hit_s && !bus.tag_ready) begin
      timeout_r <= 1'b1;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  assign bus.timeout = timeout_r;
`else
  assign timeout_hit_s = 1'b0;
  assign bus.timeout   = 1'b0;
`endif

  // Next-state decode; a start pulse aborts whatever is in progress
  always_comb begin
    next_s = state_r;
    if (bus.start) begin
      next_s = COLLECT;
    end else begin
      case (state_r)
        IDLE:    next_s = IDLE;
        COLLECT: begin
          if (bus.tag_ready) begin
            next_s = COMPARE;
          end else if (timeout_hit_s) begin
            next_s = FLUSH;
          end else begin
            next_s = COLLECT;
          end
        end
        COMPARE: next_s = match_s ? RELEASE : FLUSH;
        RELEASE: next_s = empty_s ? DONE : RELEASE;
        FLUSH:   next_s = DONE;
        DONE:    next_s = DONE;
        default: next_s = IDLE;
      endcase
    end
  end

  // Block storage; contents never leave unless out_valid is set
  always_ff @(posedge clk_out) begin
    if (push_s && !i_reset && !bus.start) begin
      mem_r[wr_ptr_r] <= bus.pt_block;
    end
  end

  // State, FIFO pointers, tag latches and sticky flags
  always_ff @(posedge clk_out) begin
    if (i_reset) begin
      state_r     <= IDLE;
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      fill_r      <= {CW{1'b0}};
      count_r     <= {CW{1'b0}};
      comp_tag_r  <= {128{1'b0}};
      exp_tag_r   <= {128{1'b0}};
      auth_ok_r   <= 1'b0;
      auth_fail_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (bus.start) begin
      state_r     <= next_s;
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      fill_r      <= {CW{1'b0}};
      count_r     <= {CW{1'b0}};
      comp_tag_r  <= {128{1'b0}};
      exp_tag_r   <= {128{1'b0}};
      auth_ok_r   <= 1'b0;
      auth_fail_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
        fill_r   <= fill_r + CW'(1);
        count_r  <= (count_r == CW'(DEPTH)) ? count_r : count_r + CW'(1);
      end else if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        fill_r   <= fill_r - CW'(1);
      end else if (state_r == FLUSH) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
        fill_r   <= {CW{1'b0}};
      end else begin
        fill_r <= fill_r;
      end
      if ((state_r == COLLECT) && bus.pt_valid && full_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
      if ((state_r == COLLECT) && bus.tag_ready) begin
        comp_tag_r <= bus.computed_tag;
        exp_tag_r  <= bus.expected_tag;
      end else begin
        comp_tag_r <= comp_tag_r;
      end
      if (state_r == COMPARE) begin
        auth_ok_r   <= match_s;
        auth_fail_r <= !match_s;
      end else if (timeout_hit_s && !bus.tag_ready) begin
        auth_fail_r <= 1'b1;
      end else begin
        auth_ok_r <= auth_ok_r;
      end
    end
  end

  assign bus.pt_ready    = (state_r == COLLECT) && !full_s;
  assign bus.out_valid   = out_valid_s;
  assign bus.out_block   = out_valid_s ? mem_r[rd_ptr_r] : {128{1'b0}};
  assign bus.auth_ok     = auth_ok_r;
  assign bus.auth_fail   = auth_fail_r;
  assign bus.overflow    = overflow_r;
  assign bus.busy        = (state_r == COLLECT) || (state_r == COMPARE) ||
                           (state_r == RELEASE) || (state_r == FLUSH);
  assign bus.block_count = count_r;
endmodule

// File: tb/tb_gcm_auth_release.sv
// Directed bench for gcm_auth_release with a scoreboard of expected released blocks.
module tb_gcm_auth_release;
  localparam int DEPTH = 4;

  logic clk_out = 1'b0;
  logic i_reset;
  int   checks = 0;
  int   errors = 0;
  int   valid_a = 0;
  int   v0;
  logic [127:0] qa [$];
  logic [127:0] qb [$];
  logic [127:0] tag_a5;

  always #5 clk_out = ~clk_out;

  gcm_auth_release_if #(.DEPTH(DEPTH)) a_if ();
  gcm_auth_release_if #(.DEPTH(DEPTH)) b_if ();

  gcm_auth_release #(.DEPTH(DEPTH), .TAG_BITS(128), .TIMEOUT_CYCLES(16)) dut (
    .clk_out (clk_out),
    .i_reset (i_reset),
    .bus     (a_if)
  );

  gcm_auth_release #(.DEPTH(DEPTH), .TAG_BITS(96), .TIMEOUT_CYCLES(16)) dut96 (
    .clk_out (clk_out),
    .i_reset (i_reset),
    .bus     (b_if)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  task automatic start_a();
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
  endtask

  task automatic send_a(input logic [127:0] blk, input bit exp_out);
    a_if.pt_valid = 1'b1;
    a_if.pt_block = blk;
    if (exp_out) qa.push_back(blk);
    tick();
    a_if.pt_valid = 1'b0;
  endtask

  task automatic tag_a(input logic [127:0] comp, input logic [127:0] exp);
    a_if.tag_ready    = 1'b1;
    a_if.computed_tag = comp;
    a_if.expected_tag = exp;
    tick();
    a_if.tag_ready = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag);
    for (int i = 0; i < 50 && a_if.busy; i++) tick();
    chk(tag, a_if.busy, 1'b0);
  endtask

  // Scoreboard for instance A: every handshake must match the oldest expected block
  always @(negedge clk_out) begin
    if (a_if.out_valid && a_if.out_ready) begin
      valid_a++;
      chk("a_release_expected", qa.size() != 0, 1'b1);
      if (qa.size() != 0) chk("a_release_data", a_if.out_block, qa.pop_front());
    end
  end

  // Scoreboard for instance B
  always @(negedge clk_out) begin
    if (b_if.out_valid && b_if.out_ready) begin
      chk("b_release_expected", qb.size() != 0, 1'b1);
      if (qb.size() != 0) chk("b_release_data", b_if.out_block, qb.pop_front());
    end
  end

  initial begin
    tag_a5 = {16{8'hA5}};
    {a_if.start, a_if.pt_valid, a_if.tag_ready} = 3'b000;
    {b_if.start, b_if.pt_valid, b_if.tag_ready} = 3'b000;
    a_if.pt_block = 128'h0; a_if.computed_tag = 128'h0; a_if.expected_tag = 128'h0;
    b_if.pt_block = 128'h0; b_if.computed_tag = 128'h0; b_if.expected_tag = 128'h0;
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;
    i_reset = 1'b1;
    tick();
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    chk("rst_busy", a_if.busy, 1'b0);
    chk("rst_flags", {a_if.auth_ok, a_if.auth_fail, a_if.overflow, a_if.timeout}, 4'b0000);
    chk("rst_out", {a_if.out_valid, a_if.pt_ready}, 2'b00);
    chk("rst_out_block", a_if.out_block, 128'h0);
    chk("rst_count", a_if.block_count, 3'd0);
    i_reset = 1'b0;
    tick();

    // 1: three blocks, matching tag, released in order
    start_a();
    chk("t1_collect_busy", {a_if.busy, a_if.pt_ready}, 2'b11);
    send_a({16{8'h11}}, 1'b1);
    send_a({16{8'h22}}, 1'b1);
    send_a({16{8'h33}}, 1'b1);
    tag_a(tag_a5, tag_a5);
    chk("t1_compare_no_flag", {a_if.auth_ok, a_if.out_valid}, 2'b00);
    tick();
    chk("t1_auth_ok_t2", a_if.auth_ok, 1'b1);
    chk("t1_first_valid_t2", a_if.out_valid, 1'b1);
    wait_idle_a("t1_done_idle");
    chk("t1_all_released", qa.size(), 128'd0);
    chk("t1_count", a_if.block_count, 3'd3);
    tag_a(tag_a5, ~tag_a5);
    tick();
    chk("t1_tag_ignored_in_done", {a_if.auth_ok, a_if.auth_fail, a_if.busy}, 3'b100);

    // 2: LSB of expected tag flipped, nothing may be released
    start_a();
    chk("t2_flags_cleared", {a_if.auth_ok, a_if.auth_fail}, 2'b00);
    v0 = valid_a;
    send_a({16{8'h11}}, 1'b0);
    send_a({16{8'h22}}, 1'b0);
    send_a({16{8'h33}}, 1'b0);
    tag_a(tag_a5, tag_a5 ^ 128'h1);
    tick();
    chk("t2_auth_fail", {a_if.auth_fail, a_if.auth_ok, a_if.out_valid}, 3'b100);
    wait_idle_a("t2_done_idle");
    for (int i = 0; i < 3; i++) tick();
    chk("t2_no_release", valid_a, v0);

    // 3: overflow on the fifth block forces failure even with matching tags
    start_a();
    for (int i = 1; i <= 4; i++) send_a({16{8'(i)}}, 1'b0);
    a_if.pt_valid = 1'b1;
    a_if.pt_block = {16{8'h55}};
    chk("t3_full_not_ready", a_if.pt_ready, 1'b0);
    tick();
    a_if.pt_valid = 1'b0;
    chk("t3_overflow", a_if.overflow, 1'b1);
    chk("t3_count_sat", a_if.block_count, 3'd4);
    tag_a(tag_a5, tag_a5);
    tick();
    chk("t3_auth_fail", {a_if.auth_fail, a_if.auth_ok, a_if.out_valid}, 3'b100);
    wait_idle_a("t3_done_idle");

    // 4: 96-bit tag, difference confined to bits [96:127], consumer stalls
    b_if.start = 1'b1;
    tick();
    b_if.start = 1'b0;
    b_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_if.pt_valid = 1'b1;
      b_if.pt_block = {16{8'(8'h44 + 8'(i) * 8'h11)}};
      qb.push_back(b_if.pt_block);
      tick();
    end
    b_if.pt_valid = 1'b0;
    b_if.tag_ready = 1'b1;
    b_if.computed_tag = tag_a5;
    b_if.expected_tag = tag_a5 ^ 128'hFFFF_FFFF;
    tick();
    b_if.tag_ready = 1'b0;
    tick();
    chk("t4_auth_ok", {b_if.auth_ok, b_if.auth_fail}, 2'b10);
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_valid", b_if.out_valid, 1'b1);
      chk("t4_stall_block", b_if.out_block, {16{8'h44}});
      tick();
    end
    b_if.out_ready = 1'b1;
    for (int i = 0; i < 50 && b_if.busy; i++) tick();
    chk("t4_done_idle", b_if.busy, 1'b0);
    chk("t4_no_loss", qb.size(), 128'd0);

    // 5: restart in the middle of a release
    start_a();
    send_a({16{8'h11}}, 1'b1);
    send_a({16{8'h22}}, 1'b1);
    send_a({16{8'h33}}, 1'b1);
    tag_a(tag_a5, tag_a5);
    tick();
    chk("t5_releasing", a_if.out_valid, 1'b1);
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    qa.delete();
    chk("t5_abort_state", {a_if.busy, a_if.pt_ready, a_if.out_valid}, 3'b110);
    chk("t5_abort_flags", {a_if.auth_ok, a_if.auth_fail, a_if.overflow}, 3'b000);
    chk("t5_abort_count", a_if.block_count, 3'd0);

    // 6: no tag after start
    start_a();
    for (int i = 0; i < 15; i++) tick();
    chk("t6_no_early_timeout", {a_if.timeout, a_if.busy}, 2'b01);
    for (int i = 0; i < 5; i++) tick();
`ifdef GCM_AUTH_TIMEOUT_EN
    chk("t6_timeout", {a_if.timeout, a_if.auth_fail, a_if.busy}, 3'b110);
`else
    for (int i = 0; i < 80; i++) tick();
    chk("t6_no_timeout", {a_if.timeout, a_if.auth_fail, a_if.busy}, 3'b001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
